lap_recorder: RTL and testbench
===============================

Name: lap_recorder

Overview:
- Multi-slot successor to the single-bit lap-freeze FSM used by the stopwatch display path.
- Captures the running stopwatch value into a DEPTH-entry lap buffer on each lap press, and freezes the display on the captured value.
- Adds a recall mode for browsing stored laps, a clear command, and a selectable full-buffer policy.
- Sits between the stopwatch counter/BCD stage and the SSD driver; all pulse inputs come from the existing debounce/one-pulse blocks.

Parameters:
- WIDTH, 16: bit width of time_in/disp_value (4 packed BCD digits).
- DEPTH, 8: number of lap slots, ≥2.
- OVERWRITE, 1: 1 = when full, new lap overwrites oldest; 0 = when full, new lap is discarded.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- lap_pulse  input  1  single-cycle lap/unfreeze/exit command.
- view_pulse  input  1  single-cycle enter-recall / step-older command.
- clear_pulse  input  1  single-cycle clear-all command.
- time_in  input  WIDTH  live stopwatch value.
- disp_value  output  WIDTH  registered value to SSD driver.
- disp_index  output  $clog2(DEPTH+1)  lap number shown in RECALL (1 = oldest stored); 0 otherwise.
- mode  output  2  00 LIVE, 01 FROZEN, 10 RECALL.
- lap_count  output  $clog2(DEPTH+1)  number of valid stored laps.
- full  output  1  lap_count == DEPTH.

Behaviour:
- Reset (async, rst_n=0): mode=LIVE, disp_value=0, disp_index=0, lap_count=0, full=0, wr/oldest pointers=0. Buffer contents are don't-care.
- All outputs are registered. A command sampled at edge N is reflected in the outputs after edge N.
- Command priority when pulses coincide: clear_pulse > lap_pulse > view_pulse. Only the highest-priority command acts.
- clear_pulse (any state): lap_count=0, full=0, pointers=0, mode=LIVE, disp_index=0.
- LIVE:
  - Each cycle, disp_value <= time_in.
  - lap_pulse:
    - If not full: write time_in to slot wr_ptr; wr_ptr++ mod DEPTH; lap_count++.
    - If full and OVERWRITE=1: write to wr_ptr (the oldest slot); wr_ptr++ and oldest_ptr++ mod DEPTH; lap_count stays DEPTH.
    - If full and OVERWRITE=0: no write, no count change.
    - In all cases: mode<=FROZEN, disp_value<=time_in (the sampled value, whether or not it was stored).
  - view_pulse: if lap_count>0, mode<=RECALL, disp_index<=lap_count, disp_value<=newest lap. If lap_count==0, ignored.
- FROZEN:
  - disp_value holds.
  - lap_pulse: mode<=LIVE, no capture.
  - view_pulse: same as from LIVE.
- RECALL:
  - Shown slot = (oldest_ptr + disp_index - 1) mod DEPTH.
  - view_pulse: disp_index--; from 1, wraps to lap_count (newest). disp_value updates to the new slot.
  - lap_pulse: mode<=LIVE, disp_index<=0, no capture.
- full is registered, consistent with lap_count on every cycle.
- time_in changing while FROZEN or RECALL has no effect on outputs.
- Pulses held high for multiple cycles act once per cycle. Upstream guarantees single-cycle pulses.
- Reset asserted mid-operation (any mode) forces the reset values immediately, without waiting for clk.

Test Plan (DEPTH=4, WIDTH=16):
- Release reset, time_in=16'h0123 → next cycle disp_value=16'h0123, mode=00, lap_count=0, full=0.
- LIVE, time_in=16'h0150, lap_pulse → mode=01, disp_value=16'h0150, lap_count=1. Ramp time_in to 16'h0200 → disp_value stays 16'h0150. lap_pulse → mode=00, disp_value tracks 16'h0200.
- OVERWRITE=1: laps at 16'h0001, 0002, 0003, 0004, 0005 (unfreezing between) → lap_count=4, full=1. view_pulse ×5 → (disp_index, disp_value) = (4,0005),(3,0004),(2,0003),(1,0002),(4,0005).
- OVERWRITE=0, same stimulus → lap_count=4. Fifth lap shows mode=01, disp_value=16'h0005. Recall newest=16'h0004, oldest=16'h0001.
- FROZEN with lap_count=2: clear_pulse and lap_pulse in the same cycle → mode=00, lap_count=0, full=0. Following view_pulse → mode stays 00.
- In RECALL at disp_index=2, assert rst_n=0 between clock edges → all outputs zero and mode=00 before the next clk edge. After release, lap_count=0.

Source files
------------

// File: rtl/lap_recorder.sv
// Lap recorder for the stopwatch display path.
// Captures the live stopwatch value into a DEPTH-entry circular lap buffer on
// each lap press and freezes the display on it. Supports recall (browse stored
// laps newest-to-oldest with wrap), clear-all, and a full-buffer policy
// (OVERWRITE=1 drops the oldest lap, OVERWRITE=0 discards the new one).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   lap_pulse     lap capture / unfreeze / exit-recall command (single cycle)
//   view_pulse    enter recall / step to older lap (single cycle)
//   clear_pulse   clear all laps, return to live (single cycle)
//   time_in       live stopwatch value
//   disp_value    registered value to the SSD driver
//   disp_index    lap number shown in recall (1 = oldest), 0 otherwise
//   mode          00 live, 01 frozen, 10 recall
//   lap_count     number of valid stored laps
//   full          lap_count == DEPTH
module lap_recorder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter bit          OVERWRITE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         lap_pulse,
  input  logic                         view_pulse,
  input  logic                         clear_pulse,
  input  logic [WIDTH-1:0]             time_in,
  output logic [WIDTH-1:0]             disp_value,
  output logic [$clog2(DEPTH+1)-1:0]   disp_index,
  output logic [1:0]                   mode,
  output logic [$clog2(DEPTH+1)-1:0]   lap_count,
  output logic                         full
);

  localparam int unsigned IW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = IW + 1;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'b00,
    MODE_FROZEN = 2'b01,
    MODE_RECALL = 2'b10
  } mode_e;

  mode_e              mode_q,       mode_d;
  logic [WIDTH-1:0]   disp_value_q, disp_value_d;
  logic [IW-1:0]      disp_index_q, disp_index_d;
  logic [IW-1:0]      lap_count_q,  lap_count_d;
  logic               full_q,       full_d;
  logic [PW-1:0]      wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0]      oldest_ptr_q, oldest_ptr_d;
  logic               we_c;
  logic [IW-1:0]      step_idx_c;
  logic [WIDTH-1:0]   newest_val_c;
  logic [WIDTH-1:0]   step_val_c;

  logic [WIDTH-1:0]   mem_q [DEPTH];

  // Physical slot of the lap at logical offset off (0 = oldest), mod DEPTH.
  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] base,
                                            input logic [IW-1:0] off);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(off);
    if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
    return PW'(sum);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Index reached by one step toward older laps; from 1 wraps to the newest.
  assign step_idx_c   = (disp_index_q == IW'(1)) ? lap_count_q : disp_index_q - IW'(1);
  assign newest_val_c = mem_q[slot_of(oldest_ptr_q, lap_count_q - IW'(1))];
  assign step_val_c   = mem_q[slot_of(oldest_ptr_q, step_idx_c - IW'(1))];

  // Next-state and output logic.
  always_comb begin
    mode_d       = mode_q;
    disp_value_d = disp_value_q;
    disp_index_d = disp_index_q;
    lap_count_d  = lap_count_q;
    wr_ptr_d     = wr_ptr_q;
    oldest_ptr_d = oldest_ptr_q;
    we_c         = 1'b0;

    if (clear_pulse) begin
      mode_d       = MODE_LIVE;
      disp_value_d = time_in;
      disp_index_d = '0;
      lap_count_d  = '0;
      wr_ptr_d     = '0;
      oldest_ptr_d = '0;
    end else begin
      unique case (mode_q)
        MODE_LIVE: begin
          disp_value_d = time_in;
          if (lap_pulse) begin
            mode_d = MODE_FROZEN;
            if (!full_q) begin
              we_c        = 1'b1;
              wr_ptr_d    = ptr_inc(wr_ptr_q);
              lap_count_d = lap_count_q + IW'(1);
            end else if (OVERWRITE) begin
              // Full: the write slot is the oldest lap, so both pointers advance.
              we_c         = 1'b1;
              wr_ptr_d     = ptr_inc(wr_ptr_q);
              oldest_ptr_d = ptr_inc(oldest_ptr_q);
            end
          end else if (view_pulse && lap_count_q != '0) begin
            mode_d       = MODE_RECALL;
            disp_index_d = lap_count_q;
            disp_value_d = newest_val_c;
          end
        end
        MODE_FROZEN: begin
          if (lap_pulse) begin
            mode_d       = MODE_LIVE;
            disp_value_d = time_in;
          end else if (view_pulse && lap_count_q != '0) begin
            mode_d       = MODE_RECALL;
            disp_index_d = lap_count_q;
            disp_value_d = newest_val_c;
          end
        end
        MODE_RECALL: begin
          if (lap_pulse) begin
            mode_d       = MODE_LIVE;
            disp_index_d = '0;
            disp_value_d = time_in;
          end else if (view_pulse) begin
            disp_index_d = step_idx_c;
            disp_value_d = step_val_c;
          end
        end
        default: begin
          mode_d       = MODE_LIVE;
          disp_index_d = '0;
        end
      endcase
    end

    full_d = (lap_count_d == IW'(DEPTH));
  end

  // Control and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_LIVE;
      disp_value_q <= '0;
      disp_index_q <= '0;
      lap_count_q  <= '0;
      full_q       <= 1'b0;
      wr_ptr_q     <= '0;
      oldest_ptr_q <= '0;
    end else begin
      mode_q       <= mode_d;
      disp_value_q <= disp_value_d;
      disp_index_q <= disp_index_d;
      lap_count_q  <= lap_count_d;
      full_q       <= full_d;
      wr_ptr_q     <= wr_ptr_d;
      oldest_ptr_q <= oldest_ptr_d;
    end
  end

  // Lap storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we_c) mem_q[wr_ptr_q] <= time_in;
  end

  assign disp_value = disp_value_q;
  assign disp_index = disp_index_q;
  assign mode       = mode_q;
  assign lap_count  = lap_count_q;
  assign full       = full_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboarded bench for lap_recorder: two instances (DEPTH=4) with the
// overwrite and discard full-buffer policies share one stimulus stream.
// A list-based reference model predicts each cycle's outputs into per-DUT
// queues; a monitor pops and compares one entry per clock.
module tb_lap_recorder;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned IW = $clog2(D + 1);

  typedef struct {
    logic [W-1:0]  dv;
    bit            dv_chk;
    logic [IW-1:0] idx;
    logic [1:0]    mode;
    logic [IW-1:0] cnt;
    logic          full;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lap_pulse = 1'b0, view_pulse = 1'b0, clear_pulse = 1'b0;
  logic [W-1:0] time_in = '0;

  logic [W-1:0]  dv0, dv1;
  logic [IW-1:0] idx0, idx1, cnt0, cnt1;
  logic [1:0]    md0, md1;
  logic          fl0, fl1;

  lap_recorder #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b1)) u_ow (
    .clk(clk), .rst_n(rst_n), .lap_pulse(lap_pulse), .view_pulse(view_pulse),
    .clear_pulse(clear_pulse), .time_in(time_in), .disp_value(dv0),
    .disp_index(idx0), .mode(md0), .lap_count(cnt0), .full(fl0));

  lap_recorder #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b0)) u_disc (
    .clk(clk), .rst_n(rst_n), .lap_pulse(lap_pulse), .view_pulse(view_pulse),
    .clear_pulse(clear_pulse), .time_in(time_in), .disp_value(dv1),
    .disp_index(idx1), .mode(md1), .lap_count(cnt1), .full(fl1));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: laps kept as an ordered list, element 0 = oldest.
  int           m_mode[2];
  logic [W-1:0] m_dv[2];
  int           m_idx[2];
  int           m_cnt[2];
  logic [W-1:0] m_laps[2][D];
  bit           m_ow[2];

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_mode[v] = 0; m_dv[v] = '0; m_idx[v] = 0; m_cnt[v] = 0;
    end
  endtask

  task automatic model_step(input int v, input bit lap, input bit view,
                            input bit clr, input logic [W-1:0] t, output exp_t e);
    bit chk = 1'b1;
    if (clr) begin
      m_mode[v] = 0; m_idx[v] = 0; m_cnt[v] = 0; m_dv[v] = t;
      chk = 1'b0;
    end else if (lap) begin
      if (m_mode[v] == 0) begin
        if (m_cnt[v] < D) begin
          m_laps[v][m_cnt[v]] = t;
          m_cnt[v]++;
        end else if (m_ow[v]) begin
          for (int i = 0; i < D - 1; i++) m_laps[v][i] = m_laps[v][i+1];
          m_laps[v][D-1] = t;
        end
        m_mode[v] = 1;
        m_dv[v] = t;
      end else begin
        m_mode[v] = 0; m_idx[v] = 0; m_dv[v] = t;
        chk = 1'b0;
      end
    end else if (view) begin
      if (m_mode[v] != 2) begin
        if (m_cnt[v] > 0) begin
          m_mode[v] = 2;
          m_idx[v] = m_cnt[v];
          m_dv[v] = m_laps[v][m_cnt[v]-1];
        end else if (m_mode[v] == 0) begin
          m_dv[v] = t;
        end
      end else begin
        m_idx[v] = (m_idx[v] == 1) ? m_cnt[v] : m_idx[v] - 1;
        m_dv[v] = m_laps[v][m_idx[v]-1];
      end
    end else if (m_mode[v] == 0) begin
      m_dv[v] = t;
    end
    e.dv = m_dv[v];
    e.dv_chk = chk;
    e.idx = IW'(m_idx[v]);
    e.mode = 2'(m_mode[v]);
    e.cnt = IW'(m_cnt[v]);
    e.full = (m_cnt[v] == D);
  endtask

  task automatic check_dut(input string name, input exp_t e, input logic [W-1:0] dv,
                           input logic [IW-1:0] idx, input logic [1:0] md,
                           input logic [IW-1:0] cnt, input logic fl);
    vectors++;
    if (md !== e.mode || idx !== e.idx || cnt !== e.cnt || fl !== e.full ||
        (e.dv_chk && dv !== e.dv)) begin
      miscompares++;
      $display("FAIL %s t=%0t: got mode=%b idx=%0d cnt=%0d full=%b dv=%h, expected mode=%b idx=%0d cnt=%0d full=%b dv=%h%s",
               name, $time, md, idx, cnt, fl, dv, e.mode, e.idx, e.cnt, e.full, e.dv,
               e.dv_chk ? "" : "(dv unchecked)");
    end
  endtask

  task automatic check_reset(input string name);
    exp_t z;
    z.dv = '0; z.dv_chk = 1'b1; z.idx = '0; z.mode = 2'b00; z.cnt = '0; z.full = 1'b0;
    check_dut({name, "_ow"}, z, dv0, idx0, md0, cnt0, fl0);
    check_dut({name, "_disc"}, z, dv1, idx1, md1, cnt1, fl1);
  endtask

  // Drive one cycle of stimulus and record the predicted response.
  task automatic drive(input bit lap, input bit view, input bit clr, input logic [W-1:0] t);
    exp_t e0, e1;
    @(negedge clk);
    lap_pulse = lap; view_pulse = view; clear_pulse = clr; time_in = t;
    model_step(0, lap, view, clr, t, e0);
    model_step(1, lap, view, clr, t, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle_inputs();
    lap_pulse = 1'b0; view_pulse = 1'b0; clear_pulse = 1'b0;
  endtask

  // Monitor: outputs are valid every cycle, one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q0.size() > 0) begin
      e = q0.pop_front();
      check_dut("ow", e, dv0, idx0, md0, cnt0, fl0);
    end
    if (rst_n && q1.size() > 0) begin
      e = q1.pop_front();
      check_dut("disc", e, dv1, idx1, md1, cnt1, fl1);
    end
  end

  initial begin
    m_ow[0] = 1'b1;
    m_ow[1] = 1'b0;
    model_reset();

    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Live tracking, lap freeze, ramp while frozen, unfreeze.
    drive(0, 0, 0, 16'h0123);
    drive(1, 0, 0, 16'h0150);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 16'h0160 + W'(k * 16));
    drive(0, 0, 0, 16'h0200);
    drive(1, 0, 0, 16'h0200);
    drive(0, 0, 0, 16'h0201);

    // Fill past capacity, then browse with wrap.
    drive(0, 0, 1, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 0, W'(k));
      drive(1, 0, 0, 16'h0999);
    end
    for (int k = 0; k < 6; k++) drive(0, 1, 0, W'($urandom));
    drive(1, 0, 0, 16'h0300);

    // Clear beats lap while frozen; a view with no laps is ignored.
    drive(0, 0, 1, 16'h0000);
    drive(1, 0, 0, 16'h000a);
    drive(1, 0, 0, 16'h0001);
    drive(1, 0, 0, 16'h000b);
    drive(1, 0, 1, 16'h0400);
    drive(0, 1, 0, 16'h0401);
    drive(0, 1, 0, 16'h0402);

    // Reach recall index 2, then reset between clock edges.
    drive(1, 0, 0, 16'h0011);
    drive(1, 0, 0, 16'h0000);
    drive(1, 0, 0, 16'h0022);
    drive(1, 0, 0, 16'h0000);
    drive(1, 0, 0, 16'h0033);
    drive(0, 1, 0, 16'h0500);
    drive(0, 1, 0, 16'h0501);
    @(posedge clk);
    #3;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 16'h0600);
    drive(0, 1, 0, 16'h0601);

    // Randomized traffic, including coincident and repeated pulses.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(5) == 0, $urandom_range(3) == 0, $urandom_range(29) == 0,
            W'($urandom));
    end
    drive(0, 0, 0, 16'h0000);

    for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    #2;
    if (q0.size() > 0 || q1.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q0.size(), q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
